// File: rtl/bus_arbiter_if.sv
// Requester/resource handshake bundle for bus_arbiter.
// The master modport is the arbiter side; slave is the requester/resource side.
interface bus_arbiter_if #(
    parameter int CHANNELS = 2
) ();
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS-1:0] req;
    logic                mem_ready;
    logic                mem_valid;
    logic [SEL_W-1:0]    sel;
    logic [CHANNELS-1:0] grant;
    logic [CHANNELS-1:0] ack;

    modport master (
        input  req, mem_ready,
        output mem_valid, sel, grant, ack
    );

    modport slave (
        output req, mem_ready,
        input  mem_valid, sel, grant, ack
    );
endinterface

// File: rtl/bus_arbiter.sv
// Non-preemptive IDLE/BUSY arbiter sharing one resource port among CHANNELS requesters.
// Define BUS_ARBITER_ROUND_ROBIN_EN for round-robin selection; the default is fixed priority.
module bus_arbiter #(
    parameter int CHANNELS = 2
) (
    input  logic          clock,
    input  logic          reset,
    bus_arbiter_if.master bus
);
    localparam int SEL_W = $clog2(CHANNELS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic [CHANNELS-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    win;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    logic [SEL_W-1:0] ptr_q, ptr_d;

    // Walk downward so the last hit is the first requester after the pointer.
    always_comb begin
        logic [SEL_W-1:0] idx;
        win = '0;
        idx = '0;
        for (int i = CHANNELS; i >= 1; i--) begin
            idx = SEL_W'((int'(ptr_q) + i) % CHANNELS);
            if (bus.req[idx]) win = idx;
        end
    end
`else
    always_comb begin
        win = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (bus.req[SEL_W'(i)]) win = SEL_W'(i);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = BUSY;
                    grant_d = {{(CHANNELS-1){1'b0}}, 1'b1} << win;
                    sel_d   = win;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
                    ptr_d   = win;
`endif
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    state_d = IDLE;
                    grant_d = '0;
                    sel_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
            ptr_q   <= SEL_W'(CHANNELS - 1);
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.mem_valid = (state_q == BUSY);
    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    // A reset in the completion cycle abandons the transaction, so it must not ack.
    assign bus.ack       = (state_q == BUSY && bus.mem_ready && !reset) ? grant_q : '0;
endmodule
